// File: rtl/alu_rs_pkg.sv
// alu_rs shared types: datapath words, instr-queue tags, ALU op codes,
// the reservation-station entry bundle and the CDB snoop helper.
package alu_rs_pkg;

  typedef logic [31:0] WordType;
  typedef logic [3:0]  IqAddrType;
  typedef logic [3:0]  CalcCodeType;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam CalcCodeType CalcAdd  = 4'd0;
  localparam CalcCodeType CalcSub  = 4'd1;
  localparam CalcCodeType CalcSll  = 4'd2;
  localparam CalcCodeType CalcSlt  = 4'd3;
  localparam CalcCodeType CalcSltu = 4'd4;
  localparam CalcCodeType CalcXor  = 4'd5;
  localparam CalcCodeType CalcSrl  = 4'd6;
  localparam CalcCodeType CalcSra  = 4'd7;
  localparam CalcCodeType CalcOr   = 4'd8;
  localparam CalcCodeType CalcAnd  = 4'd9;
  localparam CalcCodeType CalcEq   = 4'd10;
  localparam CalcCodeType CalcNe   = 4'd11;
  localparam CalcCodeType CalcLt   = 4'd12;
  localparam CalcCodeType CalcGe   = 4'd13;
  localparam CalcCodeType CalcLtu  = 4'd14;
  localparam CalcCodeType CalcGeu  = 4'd15;

  typedef struct packed {
    logic        valid;
    CalcCodeType code;
    logic        lhs_rdy;
    WordType     lhs_val;
    IqAddrType   lhs_tag;
    logic        rhs_rdy;
    WordType     rhs_val;
    IqAddrType   rhs_tag;
    IqAddrType   pos;
  } rs_entry_t;

  // An operand captures the CDB only while it is still waiting on that tag.
  function automatic logic cdb_hit(
    input logic      en,
    input IqAddrType idx,
    input logic      rdy,
    input IqAddrType tag
  );
    return en && !rdy && (tag == idx);
  endfunction

endpackage

// File: rtl/alu_rs_picker.sv
// Lowest-index priority encoder over a request vector.
// Ports: i_req request bits; o_found any set; o_idx lowest set index.
module alu_rs_picker #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scan downwards so the last hit, i.e. the lowest index, wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops the CDB and
// issues the lowest ready entry to the ALU when it has no pending result.
// Ports: clk/rst(async low)/rdy; update_stat phase; clear_flag_in flush;
// disp_* dispatch bundle; rs_full_out; cdb_* broadcast; alu_full_in;
// alu_* issue bundle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        update_stat,
  input  logic        clear_flag_in,
  input  logic        disp_enable_in,
  input  CalcCodeType disp_calc_code_in,
  input  logic        disp_lhs_ready_in,
  input  logic        disp_rhs_ready_in,
  input  WordType     disp_lhs_in,
  input  WordType     disp_rhs_in,
  input  IqAddrType   disp_lhs_tag_in,
  input  IqAddrType   disp_rhs_tag_in,
  input  IqAddrType   disp_pos_in_iq_in,
  output logic        rs_full_out,
  input  logic        cdb_enable_in,
  input  IqAddrType   cdb_idx_in,
  input  WordType     cdb_result_in,
  input  logic        alu_full_in,
  output logic        alu_calc_enable_out,
  output CalcCodeType alu_calc_code_out,
  output WordType     alu_lhs_out,
  output WordType     alu_rhs_out,
  output IqAddrType   alu_pos_in_iq_out
);

  rs_entry_t r_ent [RS_SIZE];
  rs_entry_t w_nxt [RS_SIZE];
  rs_entry_t w_new;

  logic [RS_SIZE-1:0]  w_free_req;
  logic [RS_SIZE-1:0]  w_cand_req;
  logic [RS_SIZE-1:0]  w_vld_nxt;
  logic                w_free_found;
  logic                w_cand_found;
  logic [RS_IDX_W-1:0] w_free_idx;
  logic [RS_IDX_W-1:0] w_cand_idx;
  logic                w_issue_slot;
  logic                w_fire;
  logic                w_disp;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_free_req[i] = !r_ent[i].valid;
      w_cand_req[i] = r_ent[i].valid
                    && r_ent[i].lhs_rdy
                    && r_ent[i].rhs_rdy;
    end
  end

  alu_rs_picker #(
    .N     (RS_SIZE),
    .IDX_W (RS_IDX_W)
  ) u_free_pick (
    .i_req   (w_free_req),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  alu_rs_picker #(
    .N     (RS_SIZE),
    .IDX_W (RS_IDX_W)
  ) u_issue_pick (
    .i_req   (w_cand_req),
    .o_found (w_cand_found),
    .o_idx   (w_cand_idx)
  );

  assign w_issue_slot = !update_stat
                      && !clear_flag_in
                      && !alu_full_in;
  assign w_fire = w_issue_slot && w_cand_found;

  // Slot choice uses pre-edge validity, so a slot freed by this
  // edge's issue is only reusable on the next edge.
  assign w_disp = disp_enable_in
                && !rs_full_out
                && !clear_flag_in
                && w_free_found;

  // Incoming op, with a same-edge CDB broadcast bypassed in.
  always_comb begin
    w_new         = '0;
    w_new.valid   = True;
    w_new.code    = disp_calc_code_in;
    w_new.lhs_rdy = disp_lhs_ready_in;
    w_new.lhs_val = disp_lhs_in;
    w_new.lhs_tag = disp_lhs_tag_in;
    w_new.rhs_rdy = disp_rhs_ready_in;
    w_new.rhs_val = disp_rhs_in;
    w_new.rhs_tag = disp_rhs_tag_in;
    w_new.pos     = disp_pos_in_iq_in;
    if (cdb_hit(cdb_enable_in, cdb_idx_in,
                disp_lhs_ready_in, disp_lhs_tag_in)) begin
      w_new.lhs_rdy = True;
      w_new.lhs_val = cdb_result_in;
    end
    if (cdb_hit(cdb_enable_in, cdb_idx_in,
                disp_rhs_ready_in, disp_rhs_tag_in)) begin
      w_new.rhs_rdy = True;
      w_new.rhs_val = cdb_result_in;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_nxt[i] = r_ent[i];
      if (r_ent[i].valid) begin
        if (cdb_hit(cdb_enable_in, cdb_idx_in,
                    r_ent[i].lhs_rdy, r_ent[i].lhs_tag)) begin
          w_nxt[i].lhs_rdy = True;
          w_nxt[i].lhs_val = cdb_result_in;
        end
        if (cdb_hit(cdb_enable_in, cdb_idx_in,
                    r_ent[i].rhs_rdy, r_ent[i].rhs_tag)) begin
          w_nxt[i].rhs_rdy = True;
          w_nxt[i].rhs_val = cdb_result_in;
        end
      end
    end
    if (w_fire) begin
      w_nxt[w_cand_idx].valid = False;
    end
    if (w_disp) begin
      w_nxt[w_free_idx] = w_new;
    end
    if (clear_flag_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        w_nxt[i].valid = False;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_vld_nxt[i] = w_nxt[i].valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_ent[i] <= '0;
      end
      rs_full_out         <= False;
      alu_calc_enable_out <= False;
      alu_calc_code_out   <= '0;
      alu_lhs_out         <= '0;
      alu_rhs_out         <= '0;
      alu_pos_in_iq_out   <= '0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_ent[i] <= w_nxt[i];
      end
      rs_full_out <= &w_vld_nxt;
      // update_stat=1 edges hold the issue bundle for the ALU to
      // sample; every other edge re-decides the valid bit.
      if (clear_flag_in) begin
        alu_calc_enable_out <= False;
      end else if (!update_stat) begin
        alu_calc_enable_out <= w_fire;
        if (w_fire) begin
          alu_calc_code_out <= r_ent[w_cand_idx].code;
          alu_lhs_out       <= r_ent[w_cand_idx].lhs_val;
          alu_rhs_out       <= r_ent[w_cand_idx].rhs_val;
          alu_pos_in_iq_out <= r_ent[w_cand_idx].pos;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed scenarios plus random traffic
// checked against a slot-array reference model of the station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        update_stat;
  logic        clear_flag_in;
  logic        disp_enable_in;
  CalcCodeType disp_calc_code_in;
  logic        disp_lhs_ready_in;
  logic        disp_rhs_ready_in;
  WordType     disp_lhs_in;
  WordType     disp_rhs_in;
  IqAddrType   disp_lhs_tag_in;
  IqAddrType   disp_rhs_tag_in;
  IqAddrType   disp_pos_in_iq_in;
  logic        rs_full_out;
  logic        cdb_enable_in;
  IqAddrType   cdb_idx_in;
  WordType     cdb_result_in;
  logic        alu_full_in;
  logic        alu_calc_enable_out;
  CalcCodeType alu_calc_code_out;
  WordType     alu_lhs_out;
  WordType     alu_rhs_out;
  IqAddrType   alu_pos_in_iq_out;

  alu_rs #(.RS_SIZE(RS), .RS_IDX_W(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .update_stat         (update_stat),
    .clear_flag_in       (clear_flag_in),
    .disp_enable_in      (disp_enable_in),
    .disp_calc_code_in   (disp_calc_code_in),
    .disp_lhs_ready_in   (disp_lhs_ready_in),
    .disp_rhs_ready_in   (disp_rhs_ready_in),
    .disp_lhs_in         (disp_lhs_in),
    .disp_rhs_in         (disp_rhs_in),
    .disp_lhs_tag_in     (disp_lhs_tag_in),
    .disp_rhs_tag_in     (disp_rhs_tag_in),
    .disp_pos_in_iq_in   (disp_pos_in_iq_in),
    .rs_full_out         (rs_full_out),
    .cdb_enable_in       (cdb_enable_in),
    .cdb_idx_in          (cdb_idx_in),
    .cdb_result_in       (cdb_result_in),
    .alu_full_in         (alu_full_in),
    .alu_calc_enable_out (alu_calc_enable_out),
    .alu_calc_code_out   (alu_calc_code_out),
    .alu_lhs_out         (alu_lhs_out),
    .alu_rhs_out         (alu_rhs_out),
    .alu_pos_in_iq_out   (alu_pos_in_iq_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic g_us = 1'b1;

  // Reference model: one record per slot plus the issue register.
  logic        m_v  [RS];
  CalcCodeType m_c  [RS];
  logic        m_lr [RS];
  logic        m_rr [RS];
  WordType     m_lv [RS];
  WordType     m_rv [RS];
  IqAddrType   m_lt [RS];
  IqAddrType   m_rt [RS];
  IqAddrType   m_p  [RS];
  logic        m_full;
  logic        m_en;
  CalcCodeType m_oc;
  WordType     m_ol;
  WordType     m_or;
  IqAddrType   m_op;

  typedef struct {
    logic        full;
    logic        en;
    CalcCodeType code;
    WordType     lhs;
    WordType     rhs;
    IqAddrType   pos;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < RS; i++) m_v[i] = 1'b0;
    m_full = 1'b0;
    m_en   = 1'b0;
    m_oc   = '0;
    m_ol   = '0;
    m_or   = '0;
    m_op   = '0;
  endtask

  // Applies one clock edge's worth of the station rules to the model.
  task automatic model_step();
    int  cand;
    int  fr;
    bit  all;
    if (!rdy) return;
    if (clear_flag_in) begin
      for (int i = 0; i < RS; i++) m_v[i] = 1'b0;
      m_en   = 1'b0;
      m_full = 1'b0;
      return;
    end
    cand = -1;
    fr   = -1;
    for (int i = 0; i < RS; i++) begin
      if (cand < 0 && m_v[i] && m_lr[i] && m_rr[i]) cand = i;
      if (fr < 0 && !m_v[i]) fr = i;
    end
    if (cdb_enable_in) begin
      for (int i = 0; i < RS; i++) begin
        if (m_v[i] && !m_lr[i] && m_lt[i] == cdb_idx_in) begin
          m_lr[i] = 1'b1;
          m_lv[i] = cdb_result_in;
        end
        if (m_v[i] && !m_rr[i] && m_rt[i] == cdb_idx_in) begin
          m_rr[i] = 1'b1;
          m_rv[i] = cdb_result_in;
        end
      end
    end
    if (!update_stat) begin
      if (!alu_full_in && cand >= 0) begin
        m_en    = 1'b1;
        m_oc    = m_c[cand];
        m_ol    = m_lv[cand];
        m_or    = m_rv[cand];
        m_op    = m_p[cand];
        m_v[cand] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
    end
    if (disp_enable_in && !m_full && fr >= 0) begin
      m_v[fr]  = 1'b1;
      m_c[fr]  = disp_calc_code_in;
      m_lr[fr] = disp_lhs_ready_in;
      m_lv[fr] = disp_lhs_in;
      m_lt[fr] = disp_lhs_tag_in;
      m_rr[fr] = disp_rhs_ready_in;
      m_rv[fr] = disp_rhs_in;
      m_rt[fr] = disp_rhs_tag_in;
      m_p[fr]  = disp_pos_in_iq_in;
      if (cdb_enable_in && !m_lr[fr] && m_lt[fr] == cdb_idx_in) begin
        m_lr[fr] = 1'b1;
        m_lv[fr] = cdb_result_in;
      end
      if (cdb_enable_in && !m_rr[fr] && m_rt[fr] == cdb_idx_in) begin
        m_rr[fr] = 1'b1;
        m_rv[fr] = cdb_result_in;
      end
    end
    all = 1'b1;
    for (int i = 0; i < RS; i++) all = all && m_v[i];
    m_full = all;
  endtask

  task automatic tick();
    exp_t e;
    update_stat = g_us;
    model_step();
    @(posedge clk);
    #1;
    e.full = m_full;
    e.en   = m_en;
    e.code = m_oc;
    e.lhs  = m_ol;
    e.rhs  = m_or;
    e.pos  = m_op;
    exp_q.push_back(e);
    g_us = ~g_us;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_full", 32'(rs_full_out), 32'(e.full));
      chk("sb_en", 32'(alu_calc_enable_out), 32'(e.en));
      if (e.en) begin
        chk("sb_code", 32'(alu_calc_code_out), 32'(e.code));
        chk("sb_lhs", alu_lhs_out, e.lhs);
        chk("sb_rhs", alu_rhs_out, e.rhs);
        chk("sb_pos", 32'(alu_pos_in_iq_out), 32'(e.pos));
      end
    end
  end

  task automatic idle();
    rdy            = 1'b1;
    clear_flag_in  = 1'b0;
    disp_enable_in = 1'b0;
    cdb_enable_in  = 1'b0;
    alu_full_in    = 1'b0;
  endtask

  task automatic align();
    while (g_us != 1'b1) tick();
  endtask

  task automatic disp(input CalcCodeType c, input logic lr,
                      input WordType lv, input IqAddrType lt,
                      input logic rr, input WordType rv,
                      input IqAddrType rt, input IqAddrType p);
    disp_enable_in    = 1'b1;
    disp_calc_code_in = c;
    disp_lhs_ready_in = lr;
    disp_lhs_in       = lv;
    disp_lhs_tag_in   = lt;
    disp_rhs_ready_in = rr;
    disp_rhs_in       = rv;
    disp_rhs_tag_in   = rt;
    disp_pos_in_iq_in = p;
  endtask

  task automatic cdb(input IqAddrType idx, input WordType v);
    cdb_enable_in = 1'b1;
    cdb_idx_in    = idx;
    cdb_result_in = v;
  endtask

  task automatic wait_issue(input int budget, input string nm);
    int n;
    n = 0;
    while (alu_calc_enable_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    n_chk++;
    if (alu_calc_enable_out !== 1'b1) begin
      n_err++;
      $display("FAIL %s: no issue within %0d edges", nm, budget);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_en"}, 32'(alu_calc_enable_out), 32'd0);
    chk({nm, "_code"}, 32'(alu_calc_code_out), 32'd0);
    chk({nm, "_lhs"}, alu_lhs_out, 32'd0);
    chk({nm, "_rhs"}, alu_rhs_out, 32'd0);
    chk({nm, "_pos"}, 32'(alu_pos_in_iq_out), 32'd0);
    chk({nm, "_full"}, 32'(rs_full_out), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    IqAddrType tg;
    rst = 1'b1;
    idle();
    disp_enable_in = 1'b0;
    disp(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    disp_enable_in = 1'b0;
    cdb_idx_in     = '0;
    cdb_result_in  = '0;
    update_stat    = 1'b1;
    m_reset();
    #1 rst = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Ready dispatch: issue lasts exactly the update_stat=1 cycle.
    idle();
    align();
    disp(4'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
    tick();
    idle();
    tick();
    chk("rd_en", 32'(alu_calc_enable_out), 32'd1);
    chk("rd_code", 32'(alu_calc_code_out), 32'd0);
    chk("rd_lhs", alu_lhs_out, 32'd5);
    chk("rd_rhs", alu_rhs_out, 32'd7);
    chk("rd_pos", 32'(alu_pos_in_iq_out), 32'd3);
    tick();
    chk("rd_hold", 32'(alu_calc_enable_out), 32'd1);
    tick();
    chk("rd_drop", 32'(alu_calc_enable_out), 32'd0);

    // Wakeup a cycle after dispatch.
    align();
    disp(4'd1, 1'b1, 32'h11, 4'd0, 1'b0, 32'd0, 4'd9, 4'd4);
    tick();
    idle();
    cdb(4'd9, 32'hFFFF_FFFF);
    tick();
    idle();
    chk("wk_early", 32'(alu_calc_enable_out), 32'd0);
    wait_issue(4, "wk_issue");
    chk("wk_rhs", alu_rhs_out, 32'hFFFF_FFFF);
    chk("wk_lhs", alu_lhs_out, 32'h11);
    chk("wk_pos", 32'(alu_pos_in_iq_out), 32'd4);
    tick();
    tick();

    // Bypass: CDB on the dispatch edge.
    align();
    disp(4'd2, 1'b1, 32'h22, 4'd0, 1'b0, 32'd0, 4'd9, 4'd5);
    cdb(4'd9, 32'hFFFF_FFFF);
    tick();
    idle();
    wait_issue(1, "bp_issue");
    chk("bp_rhs", alu_rhs_out, 32'hFFFF_FFFF);
    chk("bp_pos", 32'(alu_pos_in_iq_out), 32'd5);
    tick();
    tick();

    // Fill all slots; slots 2 and 5 wait on the same tag.
    for (int i = 0; i < RS; i++) begin
      tg = (i == 2 || i == 5) ? 4'd10 : IqAddrType'(i);
      disp(4'd3, 1'b1, WordType'(i), 4'd0, 1'b0, 32'd0, tg,
           IqAddrType'(i));
      tick();
    end
    chk("full_set", 32'(rs_full_out), 32'd1);
    disp(4'd4, 1'b1, 32'd99, 4'd0, 1'b1, 32'd98, 4'd0, 4'd15);
    tick();
    chk("full_drop", 32'(rs_full_out), 32'd1);
    idle();
    align();
    cdb(4'd10, 32'h0000_ABCD);
    tick();
    idle();
    tick();
    chk("ord_en1", 32'(alu_calc_enable_out), 32'd1);
    chk("ord_pos1", 32'(alu_pos_in_iq_out), 32'd2);
    chk("ord_full", 32'(rs_full_out), 32'd0);
    tick();
    tick();
    chk("ord_en2", 32'(alu_calc_enable_out), 32'd1);
    chk("ord_pos2", 32'(alu_pos_in_iq_out), 32'd5);
    chk("ord_rhs2", alu_rhs_out, 32'h0000_ABCD);
    tick();
    tick();
    chk("ord_none", 32'(alu_calc_enable_out), 32'd0);
    clear_flag_in = 1'b1;
    tick();
    idle();

    // Backpressure from the ALU.
    align();
    disp(4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd6);
    alu_full_in = 1'b1;
    tick();
    disp_enable_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bpr_hold", 32'(alu_calc_enable_out), 32'd0);
    end
    alu_full_in = 1'b0;
    wait_issue(2, "bpr_release");
    chk("bpr_pos", 32'(alu_pos_in_iq_out), 32'd6);
    tick();
    tick();

    // Clear beats a same-edge dispatch and a ready issue.
    align();
    disp(4'd6, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd7);
    tick();
    disp(4'd7, 1'b1, 32'd5, 4'd0, 1'b1, 32'd6, 4'd0, 4'd8);
    clear_flag_in = 1'b1;
    tick();
    idle();
    chk("clr_en", 32'(alu_calc_enable_out), 32'd0);
    chk("clr_full", 32'(rs_full_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_empty", 32'(alu_calc_enable_out), 32'd0);
    end

    // Asynchronous reset with three waiting entries and a live issue.
    align();
    disp(4'd8, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd12, 4'd10);
    tick();
    disp(4'd8, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0, 4'd12, 4'd11);
    tick();
    disp(4'd9, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 4'd0, 4'd9);
    tick();
    disp(4'd8, 1'b1, 32'd3, 4'd0, 1'b0, 32'd0, 4'd12, 4'd12);
    tick();
    idle();
    chk("mr_pre_en", 32'(alu_calc_enable_out), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    m_reset();
    #1 chk_zero("mid_reset");
    @(posedge clk);
    #1 chk_zero("mid_reset_hold");
    @(negedge clk);
    rst = 1'b1;
    cdb(4'd12, 32'h1234_5678);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_empty", 32'(alu_calc_enable_out), 32'd0);
    end
    align();
    disp(4'd10, 1'b1, 32'd40, 4'd0, 1'b1, 32'd41, 4'd0, 4'd1);
    tick();
    idle();
    wait_issue(2, "mr_issue");
    chk("mr_pos", 32'(alu_pos_in_iq_out), 32'd1);
    tick();
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      rdy           = ($urandom_range(0, 15) != 0);
      clear_flag_in = ($urandom_range(0, 63) == 0);
      alu_full_in   = ($urandom_range(0, 3) == 0);
      disp_enable_in = ($urandom_range(0, 2) != 0)
                     && (!m_full || $urandom_range(0, 7) == 0);
      disp_calc_code_in = CalcCodeType'($urandom_range(0, 15));
      disp_lhs_ready_in = ($urandom_range(0, 1) == 1);
      disp_rhs_ready_in = ($urandom_range(0, 1) == 1);
      disp_lhs_in       = $urandom;
      disp_rhs_in       = $urandom;
      disp_lhs_tag_in   = IqAddrType'($urandom_range(0, 7));
      disp_rhs_tag_in   = IqAddrType'($urandom_range(0, 7));
      disp_pos_in_iq_in = IqAddrType'($urandom_range(0, 15));
      cdb_enable_in     = ($urandom_range(0, 1) == 1);
      cdb_idx_in        = IqAddrType'($urandom_range(0, 7));
      cdb_result_in     = $urandom;
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
